// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-master round-robin arbiter for a single-port on-chip RAM
// Bounded-hold round robin; read data is tagged back to its master through a latency pipeline.
module onchip_mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int READ_LATENCY = 1,
  parameter int HOLD_MAX     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic             owner;
  logic [CNT_W-1:0] hold_cnt;
  logic             req0, req1;
  logic             grant0, grant1;
  logic             read_issue;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_id;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        // owner keeps the RAM until it has used up its hold budget
        if (hold_cnt < CNT_W'(HOLD_MAX)) begin
          grant0 = ~owner;
          grant1 = owner;
        end else begin
          grant0 = owner;
          grant1 = ~owner;
        end
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    read_issue     = 1'b0;
    if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
      read_issue     = m0_read & ~m0_write;
    end else if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
      read_issue     = m1_read & ~m1_write;
    end
  end

  assign mem_chipselect = grant0 | grant1;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= 1'b0;
      hold_cnt <= '0;
    end else if (grant0 || grant1) begin
      if (grant1 == owner) begin
        if (hold_cnt != CNT_W'(HOLD_MAX))
          hold_cnt <= hold_cnt + 1'b1;
      end else begin
        owner    <= grant1;
        hold_cnt <= CNT_W'(1);
      end
    end else begin
      hold_cnt <= '0;
    end
  end

  // one tag per RAM pipeline stage so returns line up with mem_readdata
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_id    <= '0;
    end else begin
      pipe_valid[0] <= read_issue;
      pipe_id[0]    <= grant1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  assign m0_readdatavalid = ~reset & pipe_valid[READ_LATENCY-1] & ~pipe_id[READ_LATENCY-1];
  assign m1_readdatavalid = ~reset & pipe_valid[READ_LATENCY-1] &  pipe_id[READ_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - bench for onchip_mem_arbiter with HOLD_MAX 4 and 1 instances side by side
// A grant-history model predicts every cycle; directed literals pin the model.
module tb_onchip_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, preload;
  logic [11:0] a0, a1;
  logic [3:0]  be0, be1;
  logic        rd0, rd1, wr0, wr1;
  logic [31:0] wd0, wd1;

  logic        wait0 [2];
  logic        wait1 [2];
  logic        rdv0  [2];
  logic        rdv1  [2];
  logic        cs    [2];
  logic        mwr   [2];
  logic        clken [2];
  logic [31:0] rdata0 [2];
  logic [31:0] rdata1 [2];
  logic [31:0] mwd    [2];
  logic [11:0] maddr  [2];
  logic [3:0]  mbe    [2];

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] init_val(int a);
    if (a == 16) return 32'hDEADBEEF;
    if (a == 32) return 32'hAAAAAAAA;
    return 32'hC0DE0000 | 32'(a);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    logic [31:0] ram [4096];
    logic [31:0] q;
    onchip_mem_arbiter #(.HOLD_MAX(g == 0 ? 4 : 1)) dut (
      .clk(clk), .reset(reset),
      .m0_address(a0), .m0_byteenable(be0), .m0_read(rd0), .m0_write(wr0), .m0_writedata(wd0),
      .m0_waitrequest(wait0[g]), .m0_readdata(rdata0[g]), .m0_readdatavalid(rdv0[g]),
      .m1_address(a1), .m1_byteenable(be1), .m1_read(rd1), .m1_write(wr1), .m1_writedata(wd1),
      .m1_waitrequest(wait1[g]), .m1_readdata(rdata1[g]), .m1_readdatavalid(rdv1[g]),
      .mem_address(maddr[g]), .mem_byteenable(mbe[g]), .mem_chipselect(cs[g]),
      .mem_write(mwr[g]), .mem_writedata(mwd[g]), .mem_clken(clken[g]), .mem_readdata(q)
    );
    always @(posedge clk) begin
      if (preload) begin
        for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
        q <= 32'h0;
      end else if (cs[g]) begin
        q <= ram[maddr[g]];
        if (mwr[g])
          for (int b = 0; b < 4; b++)
            if (mbe[g][b]) ram[maddr[g]][8*b +: 8] <= mwd[g][8*b +: 8];
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: recent grant history per instance (-1 = idle), expected RAM contents, next-cycle return
  logic [31:0] emem [2][4096];
  int          hist [2][16];
  int          hlen [2];
  bit          exp_rdv [2];
  int          exp_rid [2];
  logic [31:0] exp_rdata [2];

  task automatic model_step(int k);
    int hm, own, run, eg, i;
    bit r0, r1, wq, rq;
    logic [11:0] ea;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    hm = (k == 0) ? 4 : 1;
    r0 = rd0 | wr0;
    r1 = rd1 | wr1;
    own = 0;
    for (i = hlen[k] - 1; i >= 0; i--)
      if (hist[k][i] >= 0) begin own = hist[k][i]; break; end
    run = 0;
    i = hlen[k] - 1;
    while (i >= 0) begin
      if (hist[k][i] != own) break;
      run++;
      i--;
    end
    if (reset)           eg = -1;
    else if (r0 && r1)   eg = (run < hm) ? own : 1 - own;
    else if (r0)         eg = 0;
    else if (r1)         eg = 1;
    else                 eg = -1;
    ea  = (eg == 0) ? a0  : (eg == 1) ? a1  : 12'h0;
    ebe = (eg == 0) ? be0 : (eg == 1) ? be1 : 4'h0;
    ewd = (eg == 0) ? wd0 : (eg == 1) ? wd1 : 32'h0;
    wq  = (eg == 0) ? wr0 : (eg == 1) ? wr1 : 1'b0;
    rq  = (eg == 0) ? rd0 : (eg == 1) ? rd1 : 1'b0;
    check($sformatf("i%0d_wait0", k), wait0[k], r0 && eg != 0);
    check($sformatf("i%0d_wait1", k), wait1[k], r1 && eg != 1);
    check($sformatf("i%0d_cs", k), cs[k], eg >= 0);
    check($sformatf("i%0d_mwr", k), mwr[k], wq);
    check($sformatf("i%0d_maddr", k), maddr[k], ea);
    check($sformatf("i%0d_mbe", k), mbe[k], ebe);
    check($sformatf("i%0d_mwd", k), mwd[k], ewd);
    check($sformatf("i%0d_clken", k), clken[k], 1);
    check($sformatf("i%0d_rdv0", k), rdv0[k], !reset && exp_rdv[k] && exp_rid[k] == 0);
    check($sformatf("i%0d_rdv1", k), rdv1[k], !reset && exp_rdv[k] && exp_rid[k] == 1);
    if (!reset && exp_rdv[k])
      check($sformatf("i%0d_rdata", k), exp_rid[k] == 0 ? rdata0[k] : rdata1[k], exp_rdata[k]);
    if (reset) begin
      exp_rdv[k] = 1'b0;
      hlen[k]    = 0;
    end else begin
      exp_rdv[k]   = eg >= 0 && rq && !wq;
      exp_rid[k]   = eg;
      exp_rdata[k] = emem[k][ea];
      if (eg >= 0 && wq)
        for (int b = 0; b < 4; b++)
          if (ebe[b]) emem[k][ea][8*b +: 8] = ewd[8*b +: 8];
      if (hlen[k] == 16) begin
        for (int j = 0; j < 15; j++) hist[k][j] = hist[k][j+1];
        hlen[k] = 15;
      end
      hist[k][hlen[k]] = eg;
      hlen[k]++;
    end
  endtask

  always @(negedge clk) begin
    if (preload)
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 4096; i++) emem[k][i] = init_val(i);
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    a0 = 0; a1 = 0; be0 = 4'hF; be1 = 4'hF; wd0 = 0; wd1 = 0;
  endtask

  function automatic int grant_of(int k);
    if ((rd0 | wr0) && !wait0[k]) return 0;
    if ((rd1 | wr1) && !wait1[k]) return 1;
    return -1;
  endfunction

  int pat [2][12];
  int exp4 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int exp1 [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    reset = 1; preload = 1; idle();
    rd0 = 1; a0 = 12'h010;
    tick();
    tick(); preload = 0;
    #2 check("rst_wait0", wait0[0], 1);
    check("rst_cs", cs[0], 0);
    tick(); reset = 0; idle();
    tick(); rd0 = 1; a0 = 12'h010;
    #2 check("rd_wait0", wait0[0], 0);
    tick(); idle();
    #2 check("rd_rdv0", rdv0[0], 1);
    check("rd_data", rdata0[0], 32'hDEADBEEF);
    check("rd_rdv1", rdv1[0], 0);

    for (int i = 0; i < 12; i++) begin
      tick();
      rd0 = 1; a0 = 12'h100 + 12'(i);
      rd1 = 1; a1 = 12'h200 + 12'(i);
      #2;
      for (int k = 0; k < 2; k++) pat[k][i] = grant_of(k);
    end
    for (int i = 0; i < 12; i++) begin
      check($sformatf("pat4_%0d", i), pat[0][i], exp4[i]);
      check($sformatf("pat1_%0d", i), pat[1][i], exp1[i]);
    end

    tick(); idle();
    tick(); wr1 = 1; a1 = 12'h020; wd1 = 32'h12345678; be1 = 4'b0011;
    tick(); idle(); rd0 = 1; a0 = 12'h020;
    tick(); idle();
    #2 check("be_rdv0", rdv0[0], 1);
    check("be_data", rdata0[0], 32'hAAAA5678);

    tick(); rd0 = 1; a0 = 12'h010;
    tick(); idle(); reset = 1;
    #2 check("flush_rdv0_a", rdv0[0], 0);
    tick(); reset = 0;
    #2 check("flush_rdv0_b", rdv0[0], 0);
    tick(); rd1 = 1; a1 = 12'h011;
    tick(); idle(); reset = 1;
    tick(); reset = 0; rd0 = 1; rd1 = 1; a0 = 12'h012; a1 = 12'h013;
    #2 check("own_wait0", wait0[0], 0);
    check("own_wait1", wait1[0], 1);
    check("own1_wait0", wait0[1], 0);

    tick(); idle(); rd0 = 1; wr0 = 1; a0 = 12'h030; wd0 = 32'h00000055;
    tick(); idle();
    #2 check("rw_rdv0", rdv0[0], 0);
    tick(); rd0 = 1; a0 = 12'h030;
    tick(); idle();
    #2 check("rw_data", rdata0[0], 32'h00000055);

    for (int i = 0; i < 120; i++) begin
      tick();
      reset = ($urandom_range(0, 39) == 0);
      rd0 = ($urandom_range(0, 3) != 0); wr0 = ($urandom_range(0, 3) == 0);
      rd1 = ($urandom_range(0, 3) != 0); wr1 = ($urandom_range(0, 3) == 0);
      a0 = 12'($urandom_range(0, 15)); a1 = 12'($urandom_range(0, 15));
      be0 = 4'($urandom); be1 = 4'($urandom);
      wd0 = $urandom; wd1 = $urandom;
    end
    tick(); reset = 0; idle();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
